// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Multiplies by iterative shift-add and divides by restoring shift-subtract,
// one step per cycle, followed by a single sign-fix cycle that commits HI/LO.
module mult_div_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 6
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_en,
    input  logic [2:0]            i_operation,
    input  logic [DATA_WIDTH-1:0] i_data_a,
    input  logic [DATA_WIDTH-1:0] i_data_b,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic                  o_busy,
    output logic                  o_div_zero
);

    localparam int unsigned W = DATA_WIDTH;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MFHI  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b110;
    localparam logic [2:0] OP_MTLO  = 3'b111;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t               state;
    logic [W-1:0]         hi;
    logic [W-1:0]         lo;
    logic [CNT_WIDTH-1:0] cnt;
    // Upper half: partial product / remainder; lower half: multiplier / quotient.
    logic [2*W-1:0]       acc;
    // Multiplicand for MUL, divisor for DIV.
    logic [W-1:0]         opnd;
    logic                 sign_lo;
    logic                 sign_hi;
    logic                 is_div;

    logic                 op_signed;
    logic                 op_is_mul;
    logic                 op_is_div;
    logic                 a_neg;
    logic                 b_neg;
    logic [W-1:0]         a_mag;
    logic [W-1:0]         b_mag;
    logic                 b_zero;
    logic                 start_mul;
    logic                 start_div;

    logic [W:0]           mul_sum;
    logic [W:0]           div_shift;
    logic [W:0]           div_diff;
    logic                 div_ge;

    logic [2*W-1:0]       prod_fix;
    logic [W-1:0]         quo_fix;
    logic [W-1:0]         rem_fix;

    // Operation decode and operand magnitudes for signed ops.
    always_comb begin
        op_signed = (i_operation == OP_MULT) || (i_operation == OP_DIV);
        op_is_mul = (i_operation == OP_MULT) || (i_operation == OP_MULTU);
        op_is_div = (i_operation == OP_DIV)  || (i_operation == OP_DIVU);
        a_neg     = op_signed & i_data_a[W-1];
        b_neg     = op_signed & i_data_b[W-1];
        a_mag     = a_neg ? -i_data_a : i_data_a;
        b_mag     = b_neg ? -i_data_b : i_data_b;
        b_zero    = (i_data_b == '0);
        start_mul = i_en && (state == S_IDLE) && op_is_mul;
        start_div = i_en && (state == S_IDLE) && op_is_div && !b_zero;
    end

    // One iteration step of each datapath.
    always_comb begin
        mul_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd : '0)};
        div_shift = {acc[2*W-1:W], acc[W-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ge    = (div_shift >= {1'b0, opnd});
    end

    // Two's-complement sign correction applied in FIX.
    always_comb begin
        prod_fix = sign_lo ? -acc : acc;
        quo_fix  = sign_lo ? -acc[W-1:0] : acc[W-1:0];
        rem_fix  = sign_hi ? -acc[2*W-1:W] : acc[2*W-1:W];
    end

    // Sequencer, iteration datapath and HI/LO architectural state.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state   <= S_IDLE;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            sign_lo <= 1'b0;
            sign_hi <= 1'b0;
            is_div  <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_mul) begin
                        acc     <= {W'(0), b_mag};
                        opnd    <= a_mag;
                        sign_lo <= a_neg ^ b_neg;
                        sign_hi <= a_neg ^ b_neg;
                        is_div  <= 1'b0;
                        cnt     <= '0;
                        o_busy  <= 1'b1;
                        state   <= S_MUL;
                    end else if (start_div) begin
                        acc     <= {W'(0), a_mag};
                        opnd    <= b_mag;
                        sign_lo <= a_neg ^ b_neg;
                        sign_hi <= a_neg;
                        is_div  <= 1'b1;
                        cnt     <= '0;
                        o_busy  <= 1'b1;
                        state   <= S_DIV;
                    end else if (i_en && (i_operation == OP_MTHI)) begin
                        hi <= i_data_a;
                    end else if (i_en && (i_operation == OP_MTLO)) begin
                        lo <= i_data_a;
                    end
                end
                S_MUL: begin
                    acc <= {mul_sum, acc[W-1:1]};
                    cnt <= cnt + CNT_WIDTH'(1);
                    if (cnt == CNT_LAST) begin
                        state <= S_FIX;
                    end
                end
                S_DIV: begin
                    if (div_ge) begin
                        acc <= {div_diff[W-1:0], acc[W-2:0], 1'b1};
                    end else begin
                        acc <= {div_shift[W-1:0], acc[W-2:0], 1'b0};
                    end
                    cnt <= cnt + CNT_WIDTH'(1);
                    if (cnt == CNT_LAST) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (is_div) begin
                        lo <= quo_fix;
                        hi <= rem_fix;
                    end else begin
                        hi <= prod_fix[2*W-1:W];
                        lo <= prod_fix[W-1:0];
                    end
                    cnt    <= '0;
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    // Read port and divide-by-zero flag are combinational toward execute.
    assign o_dout     = (i_operation == OP_MFHI) ? hi : lo;
    assign o_div_zero = i_en && op_is_div && b_zero && (state == S_IDLE);

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: reads push expected values, a monitor
// pops and compares whenever a MFHI/MFLO is accepted by the unit.
module tb_mult_div_unit;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MFHI  = 3'b100;
    localparam logic [2:0] OP_MFLO  = 3'b101;
    localparam logic [2:0] OP_MTHI  = 3'b110;
    localparam logic [2:0] OP_MTLO  = 3'b111;

    logic        i_clk = 1'b0;
    logic        i_arst;
    logic        i_en;
    logic [2:0]  i_operation;
    logic [31:0] i_data_a;
    logic [31:0] i_data_b;
    logic [31:0] o_dout;
    logic        o_busy;
    logic        o_div_zero;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    mult_div_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .i_clk       (i_clk),
        .i_arst      (i_arst),
        .i_en        (i_en),
        .i_operation (i_operation),
        .i_data_a    (i_data_a),
        .i_data_b    (i_data_b),
        .o_dout      (o_dout),
        .o_busy      (o_busy),
        .o_div_zero  (o_div_zero)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: an accepted MFHI/MFLO presents o_dout; compare against the scoreboard.
    always @(negedge i_clk) begin
        if (!i_arst && i_en && !o_busy &&
            (i_operation == OP_MFHI || i_operation == OP_MFLO)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_read", o_dout, 32'hxxxx_xxxx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name, o_dout, e.val);
            end
        end
    end

    // Single-cycle issue of an operation that is known to be accepted.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        i_en = 1'b1; i_operation = op; i_data_a = a; i_data_b = b;
        @(posedge i_clk); #1;
        i_en = 1'b0;
    endtask

    // Hold a request until the unit is idle at a clock edge, as execute does.
    task automatic issue_held(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit done;
        done = 1'b0;
        i_en = 1'b1; i_operation = op; i_data_a = a; i_data_b = b;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge i_clk);
            done = !o_busy;
            @(posedge i_clk); #1;
        end
        if (!done) check("hold_timeout", 32'd1, 32'd0);
        i_en = 1'b0;
    endtask

    task automatic read(input logic [2:0] op, input logic [31:0] exp, input string name);
        exp_t e;
        e.name = name;
        e.val  = exp;
        exp_q.push_back(e);
        issue_held(op, 32'h0, 32'h0);
    endtask

    // Count cycles with o_busy high, bounded; returns aligned just after a posedge.
    task automatic wait_idle(output int cyc);
        cyc = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge i_clk);
            if (!o_busy) break;
            cyc++;
        end
        if (o_busy) check("busy_timeout", 32'd1, 32'd0);
        @(posedge i_clk); #1;
    endtask

    initial begin
        int cyc;
        i_arst = 1'b1; i_en = 1'b0; i_operation = OP_MFHI;
        i_data_a = '0; i_data_b = '0;
        #3;
        check("reset_busy", 32'(o_busy), 32'd0);
        check("reset_hi", o_dout, 32'h0);
        check("reset_divzero", 32'(o_div_zero), 32'd0);
        @(posedge i_clk); @(posedge i_clk); #1;
        i_arst = 1'b0;

        // Signed multiply -1 * 2, and busy duration.
        issue(OP_MULT, 32'hFFFF_FFFF, 32'd2);
        wait_idle(cyc);
        check("mult_busy_cycles", 32'(cyc), 32'd33);
        read(OP_MFHI, 32'hFFFF_FFFF, "mult_neg_hi");
        read(OP_MFLO, 32'hFFFF_FFFE, "mult_neg_lo");

        // Unsigned multiplies including the full-width corner.
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_idle(cyc);
        read(OP_MFHI, 32'h0000_0001, "multu_x2_hi");
        read(OP_MFLO, 32'hFFFF_FFFE, "multu_x2_lo");
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(cyc);
        read(OP_MFHI, 32'hFFFF_FFFE, "multu_max_hi");
        read(OP_MFLO, 32'h0000_0001, "multu_max_lo");

        // Divides: signed negative dividend, unsigned, signed overflow.
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(cyc);
        check("div_busy_cycles", 32'(cyc), 32'd33);
        read(OP_MFLO, 32'hFFFF_FFFD, "div_neg_lo");
        read(OP_MFHI, 32'hFFFF_FFFF, "div_neg_hi");
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_idle(cyc);
        read(OP_MFLO, 32'd14, "divu_lo");
        read(OP_MFHI, 32'd2, "divu_hi");
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(cyc);
        read(OP_MFLO, 32'h8000_0000, "div_ovf_lo");
        read(OP_MFHI, 32'h0, "div_ovf_hi");

        // Divide by zero leaves HI/LO intact and does not start.
        issue(OP_MTHI, 32'h11, 32'h0);
        issue(OP_MTLO, 32'h22, 32'h0);
        i_en = 1'b1; i_operation = OP_DIVU; i_data_a = 32'd5; i_data_b = 32'd0;
        #1;
        check("divzero_flag", 32'(o_div_zero), 32'd1);
        @(posedge i_clk); #1;
        i_en = 1'b0;
        check("divzero_no_busy", 32'(o_busy), 32'd0);
        read(OP_MFHI, 32'h11, "divzero_hi");
        read(OP_MFLO, 32'h22, "divzero_lo");

        // Requests during busy: no div-zero flag, held MFHI sees the new HI.
        issue(OP_MULT, 32'hFFFF_FFFF, 32'd3);
        i_en = 1'b1; i_operation = OP_DIVU; i_data_a = 32'd5; i_data_b = 32'd0;
        #1;
        check("divzero_while_busy", 32'(o_div_zero), 32'd0);
        read(OP_MFHI, 32'hFFFF_FFFF, "held_mfhi");
        read(OP_MFLO, 32'hFFFF_FFFD, "held_mflo");

        // Held MTLO lands only after the multiply has committed LO.
        issue(OP_MULTU, 32'd6, 32'd7);
        i_en = 1'b1; i_operation = OP_MTLO; i_data_a = 32'h55; i_data_b = 32'h0;
        for (int k = 0; k < 100; k++) begin
            @(negedge i_clk);
            if (!o_busy) break;
        end
        check("mtlo_held_prev_lo", o_dout, 32'd42);
        @(posedge i_clk); #1;
        i_en = 1'b0;
        read(OP_MFLO, 32'h55, "mtlo_held_lo");
        read(OP_MFHI, 32'h0, "mtlo_held_hi");

        // Reset in the middle of a divide.
        issue(OP_DIV, 32'd1000, 32'd3);
        repeat (9) @(posedge i_clk);
        #1;
        i_arst = 1'b1;
        #1;
        check("rst_mid_busy", 32'(o_busy), 32'd0);
        i_operation = OP_MFHI;
        #1;
        check("rst_mid_hi", o_dout, 32'h0);
        i_operation = OP_MFLO;
        #1;
        check("rst_mid_lo", o_dout, 32'h0);
        @(posedge i_clk); #1;
        i_arst = 1'b0;
        issue(OP_MULTU, 32'd3, 32'd4);
        wait_idle(cyc);
        read(OP_MFLO, 32'd12, "post_rst_lo");
        read(OP_MFHI, 32'h0, "post_rst_hi");

        repeat (2) @(posedge i_clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
